sdram_model: RTL and testbench

Synthesizable responder for the 16-bit single-data-rate SDRAM command interface driven by the team's SDRAM controllers. It decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, stores write data in on-chip block RAM with byte masking, and returns read data after the programmed CAS latency. It replaces the MT48LC16M16 part in simulation and FPGA loopback builds, and flags protocol violations for the verification bench.

---
 rtl/sdram_model.sv | 134 +++++++++++++
 tb/tb_sdram_model.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_model.sv
// sdram_model: 16-bit SDR SDRAM responder with per-bank row tracking, byte-masked array and CL 2/3 read pipeline.
// Define SDRAM_MODEL_TRCD_CHECK_EN to build per-bank tRCD counters that flag and drop early READ/WRITE (error 3).
module sdram_model #(
    parameter int MEM_ADDR_BITS = 14,
    parameter int RCD_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        init,
    input  logic [15:0] sd_data_in,
    output logic [15:0] sd_data_out,
    output logic        sd_data_oe,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_ba,
    input  logic [1:0]  sd_dqm,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    output logic        mode_valid,
    output logic [1:0]  cas_latency,
    output logic [15:0] refresh_count,
    output logic        err,
    output logic [2:0]  err_code
);
    logic [3:0]               cmd;
    logic                     is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_rw;
    logic                     any_open, mode_ok, rcd_busy, ok;
    logic                     do_act, do_rd, do_wr, do_pre, do_ref, do_lmr;
    logic [2:0]               code_d;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [16:0]              tap_d;
    logic [3:0]               open_q;
    logic [12:0]              row_q [4];
    logic [15:0]              mem_q [2**MEM_ADDR_BITS];
    logic [15:0]              rd_word_q, out_q, refresh_q;
    logic [16:0]              s2_q, s3_q;
    logic                     rd_v1_q, oe_q, mode_valid_q, err_q;
    logic [1:0]               cl_q;
    logic [2:0]               err_code_q;

    assign cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
    assign is_act   = cmd == 4'b0011;
    assign is_rd    = cmd == 4'b0101;
    assign is_wr    = cmd == 4'b0100;
    assign is_pre   = cmd == 4'b0010;
    assign is_ref   = cmd == 4'b0001;
    assign is_lmr   = cmd == 4'b0000;
    assign is_rw    = is_rd | is_wr;
    assign any_open = |open_q;
    assign mode_ok  = (sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3) && sd_addr[2:0] == 3'd0;

`ifdef SDRAM_MODEL_TRCD_CHECK_EN
    logic [7:0] rcd_q [4];
    assign rcd_busy = rcd_q[sd_ba] != 8'd0;
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            rcd_q[b] <= init ? 8'd0 :
                        (do_act && sd_ba == 2'(b)) ? 8'(RCD_CYCLES - 1) :
                        (rcd_q[b] != 8'd0) ? rcd_q[b] - 8'd1 : 8'd0;
    end
`else
    assign rcd_busy = 1'b0;
`endif

    // Mode check first: nothing but LOAD_MODE/PRECHARGE is meaningful before a mode is set.
    assign code_d = ((is_act | is_rw | is_ref) && !mode_valid_q) ? 3'd6 :
                    (is_rw && !open_q[sd_ba])                    ? 3'd1 :
                    (is_rw && rcd_busy)                          ? 3'd3 :
                    (is_act && open_q[sd_ba])                    ? 3'd2 :
                    (is_ref && any_open)                         ? 3'd5 :
                    (is_lmr && any_open)                         ? 3'd7 :
                    (is_lmr && !mode_ok)                         ? 3'd4 : 3'd0;
    assign ok     = code_d == 3'd0;
    assign do_act = is_act & ok;
    assign do_rd  = is_rd & ok;
    assign do_wr  = is_wr & ok & ~init;
    assign do_pre = is_pre & ok;
    assign do_ref = is_ref & ok;
    assign do_lmr = is_lmr & ok;
    assign idx    = MEM_ADDR_BITS'({sd_ba, row_q[sd_ba], sd_addr[8:0]});
    assign tap_d  = (cl_q == 2'd2) ? s2_q : s3_q;

    // Array has no reset so contents survive init; the read port is registered every cycle.
    always_ff @(posedge clk) begin
        if (do_wr && !sd_dqm[0]) mem_q[idx][7:0] <= sd_data_in[7:0];
        if (do_wr && !sd_dqm[1]) mem_q[idx][15:8] <= sd_data_in[15:8];
        rd_word_q <= mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (init) begin
            open_q       <= 4'b0;
            mode_valid_q <= 1'b0;
            cl_q         <= 2'd3;
            refresh_q    <= 16'd0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            rd_v1_q      <= 1'b0;
            s2_q         <= 17'd0;
            s3_q         <= 17'd0;
            oe_q         <= 1'b0;
            out_q        <= 16'd0;
        end else begin
            if (!ok) begin
                err_q <= 1'b1;
                if (!err_q) err_code_q <= code_d;
            end
            if (do_act) begin
                open_q[sd_ba] <= 1'b1;
                row_q[sd_ba]  <= sd_addr;
            end
            if ((do_rd || do_wr) && sd_addr[10]) open_q[sd_ba] <= 1'b0;
            if (do_pre) open_q <= sd_addr[10] ? 4'b0 : open_q & ~(4'b1 << sd_ba);
            if (do_ref) refresh_q <= refresh_q + 16'd1;
            if (do_lmr) begin
                mode_valid_q <= 1'b1;
                cl_q         <= sd_addr[5:4];
            end
            rd_v1_q <= do_rd;
            s2_q    <= {rd_v1_q, rd_v1_q ? rd_word_q : 16'd0};
            s3_q    <= s2_q;
            oe_q    <= tap_d[16];
            out_q   <= tap_d[15:0];
        end
    end

    assign sd_data_out   = out_q;
    assign sd_data_oe    = oe_q;
    assign mode_valid    = mode_valid_q;
    assign cas_latency   = cl_q;
    assign refresh_count = refresh_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: directed test-plan sequence plus random command stream checked every cycle against a behavioural model.
module tb_sdram_model;
    localparam int AW = 14, RCD = 2;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, INH = 4'b1111, BST = 4'b0110;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic [15:0] sd_data_in = '0, sd_data_out;
    logic        sd_data_oe;
    logic [12:0] sd_addr = '0;
    logic [1:0]  sd_ba = '0, sd_dqm = '0;
    logic        sd_cs = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
    logic        mode_valid, err;
    logic [1:0]  cas_latency;
    logic [15:0] refresh_count;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    sdram_model #(.MEM_ADDR_BITS(AW), .RCD_CYCLES(RCD)) dut (
        .clk(clk), .init(init), .sd_data_in(sd_data_in), .sd_data_out(sd_data_out),
        .sd_data_oe(sd_data_oe), .sd_addr(sd_addr), .sd_ba(sd_ba), .sd_dqm(sd_dqm),
        .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
        .mode_valid(mode_valid), .cas_latency(cas_latency), .refresh_count(refresh_count),
        .err(err), .err_code(err_code)
    );

    int n_chk = 0, n_fail = 0;
    int e = 0, n_oe = 0, last_oe_e = -1, last_rd_e = -100;
    logic [15:0] last_data = '0;
    bit   m_open [4];
    int   m_row [4], m_act [4];
    bit   m_mv, m_err;
    int   m_cl, m_rc, m_code;
    logic [7:0]  m_byte [int];
    bit          exp_v [int];
    logic [15:0] exp_d [int], exp_m [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    function automatic int widx(int ba, int row, int col);
        return ((ba << 22) | (row << 9) | col) & ((1 << AW) - 1);
    endfunction

    task automatic model(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m, input logic rst);
        int n = 0;
        bit any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        bit rw = (c == RD) || (c == WR);
        bit early = 0;
        if (rst) begin
            for (int b = 0; b < 4; b++) m_open[b] = 0;
            m_mv = 0; m_cl = 3; m_rc = 0; m_err = 0; m_code = 0;
            for (int k = e; k <= e + 3; k++) if (exp_v.exists(k)) exp_v.delete(k);
            return;
        end
`ifdef SDRAM_MODEL_TRCD_CHECK_EN
        early = e < m_act[ba] + RCD;
`endif
        if ((c == ACT || rw || c == REF) && !m_mv) n = 6;
        else if (rw && !m_open[ba]) n = 1;
        else if (rw && early) n = 3;
        else if (c == ACT && m_open[ba]) n = 2;
        else if (c == REF && any) n = 5;
        else if (c == LMR && any) n = 7;
        else if (c == LMR && !((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0)) n = 4;
        if (n != 0) begin
            if (!m_err) m_code = n;
            m_err = 1;
            return;
        end
        case (c)
            ACT: begin m_open[ba] = 1; m_row[ba] = int'(a); m_act[ba] = e; end
            WR: begin
                int ix = widx(ba, m_row[ba], int'(a[8:0]));
                for (int l = 0; l < 2; l++) if (!m[l]) m_byte[ix*2+l] = d[l*8 +: 8];
            end
            RD: begin
                int ix = widx(ba, m_row[ba], int'(a[8:0]));
                logic [15:0] v = '0, mk = '0;
                for (int l = 0; l < 2; l++)
                    if (m_byte.exists(ix*2+l)) begin v[l*8 +: 8] = m_byte[ix*2+l]; mk[l*8 +: 8] = 8'hFF; end
                exp_v[e+m_cl] = 1; exp_d[e+m_cl] = v; exp_m[e+m_cl] = mk;
            end
            PRE: if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 0; else m_open[ba] = 0;
            REF: m_rc = (m_rc + 1) & 16'hFFFF;
            LMR: begin m_mv = 1; m_cl = int'(a[6:4]); end
            default: ;
        endcase
        if (rw && a[10]) m_open[ba] = 0;
    endtask

    task automatic sample();
        bit ev = exp_v.exists(e);
        check("oe", 32'(sd_data_oe), 32'(ev));
        if (ev) begin
            check("rdata", 32'(sd_data_out & exp_m[e]), 32'(exp_d[e] & exp_m[e]));
            last_data = sd_data_out; last_oe_e = e; n_oe++;
        end else check("rdata_idle", 32'(sd_data_out), 0);
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), m_code);
        check("mode_valid", 32'(mode_valid), 32'(m_mv));
        check("cas_latency", 32'(cas_latency), m_cl);
        check("refresh_count", 32'(refresh_count), m_rc);
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] m, input logic rst);
        {sd_cs, sd_ras, sd_cas, sd_we} = c;
        sd_ba = ba; sd_addr = a; sd_data_in = d; sd_dqm = m; init = rst;
        if (c == RD) last_rd_e = e + 1;
        @(posedge clk);
        e++;
        model(c, ba, a, d, m, rst);
        @(negedge clk);
        sample();
    endtask

    task automatic idle(input int n);
        repeat (n) step(NOP, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int re;
        step(NOP, 0, 0, 0, 0, 1);
        step(NOP, 0, 0, 0, 0, 1);
        step(LMR, 0, 13'h230, 0, 0, 0);
        check("tp_mode_valid", 32'(mode_valid), 1);
        check("tp_cl3", 32'(cas_latency), 3);
        check("tp_no_err", 32'(err), 0);
        step(ACT, 1, 13'h0AB, 0, 0, 0);
        idle(1);
        step(WR, 1, 13'h012, 16'h0000, 2'b00, 0);
        step(WR, 1, 13'h012, 16'h5A5A, 2'b01, 0);
        step(RD, 1, 13'h412, 0, 2'b11, 0);
        re = e;
        idle(4);
        check("tp_masked_data", 32'(last_data), 32'h5A00);
        check("tp_cl3_latency", last_oe_e - re, 3);
        step(LMR, 0, 13'h220, 0, 0, 0);
        check("tp_bank1_idle", 32'(err), 0);
        check("tp_cl2", 32'(cas_latency), 2);
        step(ACT, 0, 13'h005, 0, 0, 0);
        idle(1);
        step(WR, 0, 13'h001, 16'h1111, 2'b00, 0);
        step(WR, 0, 13'h002, 16'h2222, 2'b00, 0);
        n_oe = 0;
        step(RD, 0, 13'h001, 0, 0, 0);
        re = e;
        step(RD, 0, 13'h402, 0, 0, 0);
        idle(4);
        check("tp_b2b_count", n_oe, 2);
        check("tp_b2b_last", 32'(last_data), 32'h2222);
        check("tp_b2b_latency", last_oe_e - re, 3);
        n_oe = 0;
        step(RD, 2, 13'h000, 0, 0, 0);
        idle(3);
        check("tp_idle_rd_oe", n_oe, 0);
        check("tp_idle_rd_code", 32'(err_code), 1);
        step(ACT, 3, 13'h001, 0, 0, 0);
        step(ACT, 3, 13'h001, 0, 0, 0);
        check("tp_code_held", 32'(err_code), 1);
        step(NOP, 0, 0, 0, 0, 1);
        step(LMR, 0, 13'h230, 0, 0, 0);
        step(ACT, 0, 13'h001, 0, 0, 0);
        n_oe = 0;
        step(RD, 0, 13'h000, 0, 0, 0);
        idle(4);
`ifdef SDRAM_MODEL_TRCD_CHECK_EN
        check("tp_trcd_code", 32'(err_code), 3);
        check("tp_trcd_drop", n_oe, 0);
`else
        check("tp_trcd_off_err", 32'(err), 0);
        check("tp_trcd_off_oe", n_oe, 1);
`endif
        step(NOP, 0, 0, 0, 0, 1);
        step(LMR, 0, 13'h230, 0, 0, 0);
        repeat (4) step(REF, 0, 0, 0, 0, 0);
        check("tp_refresh4", 32'(refresh_count), 4);
        step(ACT, 0, 13'h002, 0, 0, 0);
        idle(1);
        n_oe = 0;
        step(RD, 0, 13'h003, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 1);
        idle(4);
        check("tp_flush_oe", n_oe, 0);
        check("tp_flush_rc", 32'(refresh_count), 0);
        check("tp_flush_mv", 32'(mode_valid), 0);
        check("tp_flush_err", 32'(err), 0);
        // Random phase: small row/column ranges so reads often hit earlier writes.
        repeat (2500) begin
            int r = $urandom_range(0, 99);
            logic [1:0]  ba = 2'($urandom_range(0, 3));
            logic [12:0] row = 13'($urandom_range(0, 3));
            logic [12:0] ca = 13'($urandom_range(0, 7)) | ($urandom_range(0, 3) == 0 ? 13'h400 : 13'h0);
            logic [15:0] d = 16'($urandom);
            logic [1:0]  m = 2'($urandom_range(0, 3));
            logic [12:0] md = 13'($urandom_range(1, 4) << 4) | ($urandom_range(0, 3) == 0 ? 13'h1 : 13'h0);
            if (r < 2) step(NOP, 0, 0, 0, 0, 1);
            else if (!m_mv && r < 50) step(LMR, 0, 13'($urandom_range(2, 3) << 4), 0, 0, 0);
            else if (r < 27) step(ACT, ba, row, 0, 0, 0);
            else if (r < 42) step(WR, ba, ca, d, m, 0);
            else if (r < 62) step(RD, ba, ca, 0, m, 0);
            else if (r < 72) step(PRE, ba, $urandom_range(0, 2) == 0 ? 13'h400 : 13'h0, 0, 0, 0);
            else if (r < 76) step(REF, 0, 0, 0, 0, 0);
            else if (r < 80 && e - last_rd_e > 4) step(LMR, 0, md, 0, 0, 0);
            else step(r < 90 ? NOP : (r < 95 ? INH : BST), ba, row, d, m, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
